perf_counter_unit: RTL and testbench

Memory-mapped performance-counter block inside `cpu`, sitting on the data-side MMIO decode next to the UART. It counts cycles, retired instructions, retired branches and branch mispredictions. It exposes live and snapshot values to software via loads and lets software clear or pause counting via stores. The live cycle and instruction counts also drive `cycle_counter` / `instruction_counter` for benches to read hierarchically.

---
 rtl/perf_pkg.sv | 23 ++
 rtl/perf_counter_unit_counter.sv | 48 ++++
 rtl/perf_counter_unit.sv | 122 ++++++++++++
 tb/tb_perf_counter_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter MMIO window: register
// offsets, CTRL bit positions and the default counter width.
package perf_pkg;

    localparam int PERF_CNT_WIDTH = 32;

    localparam logic [7:0] PERF_CYCLE     = 8'h10;
    localparam logic [7:0] PERF_INSTRET   = 8'h14;
    localparam logic [7:0] PERF_CLEAR     = 8'h18;
    localparam logic [7:0] PERF_BRANCH    = 8'h1C;
    localparam logic [7:0] PERF_MISPRED   = 8'h20;
    localparam logic [7:0] PERF_CTRL      = 8'h24;
    localparam logic [7:0] PERF_SNAP_BASE = 8'h30;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SNAP_BIT = 1;

    // Offset of snapshot register idx (0 cycles, 1 instret, 2 branches, 3 mispredicts)
    function automatic logic [7:0] perf_snap_off(input logic [1:0] idx);
        return PERF_SNAP_BASE + {4'h0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/perf_counter_unit_counter.sv
// One wrapping event counter with clear priority and a snapshot copy.
// The snapshot captures the live value before this cycle's update.
module perf_counter
    import perf_pkg::*;
#(
    parameter int                   CNT_WIDTH = PERF_CNT_WIDTH,
    parameter logic [CNT_WIDTH-1:0] INIT      = {CNT_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] live,
    output logic [CNT_WIDTH-1:0] snapshot
);

    logic [CNT_WIDTH-1:0] live_r;
    logic [CNT_WIDTH-1:0] snap_r;

    // Live count: clear beats increment, increment wraps modulo 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            live_r <= INIT;
        end else if (clr) begin
            live_r <= {CNT_WIDTH{1'b0}};
        end else if (inc) begin
            live_r <= live_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            live_r <= live_r;
        end
    end

    // Snapshot copy of the pre-update live value
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r <= {CNT_WIDTH{1'b0}};
        end else if (snap) begin
            snap_r <= live_r;
        end else begin
            snap_r <= snap_r;
        end
    end

    assign live     = live_r;
    assign snapshot = snap_r;

endmodule

// File: rtl/perf_counter_unit.sv
// Memory-mapped performance counters: cycles, retired instructions,
// retired branches and mispredictions, with clear, pause and snapshot.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int                   CNT_WIDTH    = PERF_CNT_WIDTH,
    parameter int                   ADDR_WIDTH   = 8,
    parameter logic [CNT_WIDTH-1:0] INSTRET_INIT = {CNT_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mmio_addr,
    input  logic                  mmio_re,
    input  logic                  mmio_we,
    input  logic [31:0]           mmio_wdata,
    output logic [31:0]           mmio_rdata,
    input  logic                  inst_retire,
    input  logic                  branch_retire,
    input  logic                  branch_mispredict,
    output logic [CNT_WIDTH-1:0]  cycle_counter,
    output logic [CNT_WIDTH-1:0]  instruction_counter
);

    logic [ADDR_WIDTH-1:0] addr_word_s;
    logic                  wr_clear_s;
    logic                  wr_ctrl_s;
    logic                  snap_s;
    logic                  en_r;
    logic                  inc_cyc_s;
    logic                  inc_inst_s;
    logic                  inc_br_s;
    logic                  inc_mis_s;
    logic [CNT_WIDTH-1:0]  live_cyc_s;
    logic [CNT_WIDTH-1:0]  live_inst_s;
    logic [CNT_WIDTH-1:0]  live_br_s;
    logic [CNT_WIDTH-1:0]  live_mis_s;
    logic [CNT_WIDTH-1:0]  snap_cyc_s;
    logic [CNT_WIDTH-1:0]  snap_inst_s;
    logic [CNT_WIDTH-1:0]  snap_br_s;
    logic [CNT_WIDTH-1:0]  snap_mis_s;
    logic [31:0]           rd_next_s;
    logic [31:0]           rdata_r;
    logic                  unused_s;

    // Store decode and qualified increment enables (old en applies this cycle)
    always_comb begin
        addr_word_s = {mmio_addr[ADDR_WIDTH-1:2], 2'b00};
        wr_clear_s  = mmio_we && (addr_word_s == ADDR_WIDTH'(PERF_CLEAR));
        wr_ctrl_s   = mmio_we && (addr_word_s == ADDR_WIDTH'(PERF_CTRL));
        snap_s      = wr_ctrl_s && mmio_wdata[CTRL_SNAP_BIT];
        inc_cyc_s   = en_r;
        inc_inst_s  = en_r && inst_retire;
        inc_br_s    = en_r && inst_retire && branch_retire;
        inc_mis_s   = en_r && inst_retire && branch_retire && branch_mispredict;
    end

    assign unused_s = ^{mmio_wdata[31:2], mmio_addr[1:0]};

    // CTRL enable bit: resets to counting, updated by any CTRL store
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r <= 1'b1;
        end else if (wr_ctrl_s) begin
            en_r <= mmio_wdata[CTRL_EN_BIT];
        end else begin
            en_r <= en_r;
        end
    end

    perf_counter #(.CNT_WIDTH(CNT_WIDTH), .INIT({CNT_WIDTH{1'b0}})) u_cycles (
        .clk(clk), .rst(rst), .inc(inc_cyc_s), .clr(wr_clear_s), .snap(snap_s),
        .live(live_cyc_s), .snapshot(snap_cyc_s)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH), .INIT(INSTRET_INIT)) u_instret (
        .clk(clk), .rst(rst), .inc(inc_inst_s), .clr(wr_clear_s), .snap(snap_s),
        .live(live_inst_s), .snapshot(snap_inst_s)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH), .INIT({CNT_WIDTH{1'b0}})) u_branches (
        .clk(clk), .rst(rst), .inc(inc_br_s), .clr(wr_clear_s), .snap(snap_s),
        .live(live_br_s), .snapshot(snap_br_s)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH), .INIT({CNT_WIDTH{1'b0}})) u_mispred (
        .clk(clk), .rst(rst), .inc(inc_mis_s), .clr(wr_clear_s), .snap(snap_s),
        .live(live_mis_s), .snapshot(snap_mis_s)
    );

    // Read mux over current register contents; unmapped offsets read 0
    always_comb begin
        rd_next_s = 32'h0000_0000;
        case (addr_word_s)
            ADDR_WIDTH'(PERF_CYCLE):        rd_next_s = 32'(live_cyc_s);
            ADDR_WIDTH'(PERF_INSTRET):      rd_next_s = 32'(live_inst_s);
            ADDR_WIDTH'(PERF_BRANCH):       rd_next_s = 32'(live_br_s);
            ADDR_WIDTH'(PERF_MISPRED):      rd_next_s = 32'(live_mis_s);
            ADDR_WIDTH'(PERF_CTRL):         rd_next_s[CTRL_EN_BIT] = en_r;
            ADDR_WIDTH'(perf_snap_off(2'd0)): rd_next_s = 32'(snap_cyc_s);
            ADDR_WIDTH'(perf_snap_off(2'd1)): rd_next_s = 32'(snap_inst_s);
            ADDR_WIDTH'(perf_snap_off(2'd2)): rd_next_s = 32'(snap_br_s);
            ADDR_WIDTH'(perf_snap_off(2'd3)): rd_next_s = 32'(snap_mis_s);
            default:                        rd_next_s = 32'h0000_0000;
        endcase
    end

    // Load data register: captured on a load strobe, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (mmio_re) begin
            rdata_r <= rd_next_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign mmio_rdata          = rdata_r;
    assign cycle_counter       = live_cyc_s;
    assign instruction_counter = live_inst_s;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit with a load-data scoreboard and a
// small reference model of the counters.
module tb_perf_counter_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  mmio_addr;
    logic        mmio_re;
    logic        mmio_we;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        inst_retire;
    logic        branch_retire;
    logic        branch_mispredict;
    logic [31:0] cycle_counter;
    logic [31:0] instruction_counter;

    // Second instance whose instret starts at all-ones, for the wrap case
    logic        w_retire;
    logic [31:0] w_rdata;
    logic [31:0] w_cyc;
    logic [31:0] w_inst;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_zero;

    int errors;
    int checks;

    logic [31:0] cyc_m, inst_m, br_m, mis_m;
    logic [31:0] scyc_m, sinst_m, sbr_m, smis_m;
    logic [31:0] total_m;
    logic        en_m;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    localparam logic [2:0] PAT [9] = '{3'b100, 3'b110, 3'b100, 3'b111, 3'b010,
                                       3'b100, 3'b110, 3'b100, 3'b011};

    perf_counter_unit dut (
        .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_re(mmio_re),
        .mmio_we(mmio_we), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .inst_retire(inst_retire), .branch_retire(branch_retire),
        .branch_mispredict(branch_mispredict), .cycle_counter(cycle_counter),
        .instruction_counter(instruction_counter)
    );

    perf_counter_unit #(.INSTRET_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .mmio_addr(w_addr), .mmio_re(w_zero),
        .mmio_we(w_zero), .mmio_wdata(w_wdata), .mmio_rdata(w_rdata),
        .inst_retire(w_retire), .branch_retire(w_zero),
        .branch_mispredict(w_zero), .cycle_counter(w_cyc),
        .instruction_counter(w_inst)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        logic [7:0] a;
        a = {addr[7:2], 2'b00};
        case (a)
            8'h10:   return cyc_m;
            8'h14:   return inst_m;
            8'h1C:   return br_m;
            8'h20:   return mis_m;
            8'h24:   return {31'h0, en_m};
            8'h30:   return scyc_m;
            8'h34:   return sinst_m;
            8'h38:   return sbr_m;
            8'h3C:   return smis_m;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge; the model takes the inputs present at that edge
    task automatic tick();
        logic [7:0] a;
        @(posedge clk);
        a = {mmio_addr[7:2], 2'b00};
        if (rst) begin
            cyc_m = 32'h0; inst_m = 32'h0; br_m = 32'h0; mis_m = 32'h0;
            scyc_m = 32'h0; sinst_m = 32'h0; sbr_m = 32'h0; smis_m = 32'h0;
            en_m = 1'b1; total_m = 32'h0;
        end else begin
            total_m = total_m + 32'd1;
            if (mmio_we && a == 8'h24 && mmio_wdata[1]) begin
                scyc_m = cyc_m; sinst_m = inst_m; sbr_m = br_m; smis_m = mis_m;
            end
            if (mmio_we && a == 8'h18) begin
                cyc_m = 32'h0; inst_m = 32'h0; br_m = 32'h0; mis_m = 32'h0;
            end else if (en_m) begin
                cyc_m = cyc_m + 32'd1;
                if (inst_retire) inst_m = inst_m + 32'd1;
                if (inst_retire && branch_retire) br_m = br_m + 32'd1;
                if (inst_retire && branch_retire && branch_mispredict) mis_m = mis_m + 32'd1;
            end
            if (mmio_we && a == 8'h24) en_m = mmio_wdata[0];
        end
        #1;
    endtask

    task automatic pop_check();
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%08h expected=none", mmio_rdata);
        end else begin
            checks--;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, mmio_rdata, e);
        end
    endtask

    // Load: expectation queued at issue, compared when the data appears
    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        mmio_addr = addr;
        mmio_re   = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        mmio_re = 1'b0;
        pop_check();
    endtask

    task automatic st(input logic [7:0] addr, input logic [31:0] data);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_we    = 1'b1;
        tick();
        mmio_we    = 1'b0;
        mmio_wdata = 32'h0;
    endtask

    // Directed sequence
    initial begin
        logic [31:0] p;
        errors = 0; checks = 0;
        rst = 1'b1; mmio_addr = 8'h00; mmio_re = 1'b0; mmio_we = 1'b0;
        mmio_wdata = 32'h0; inst_retire = 1'b0; branch_retire = 1'b0;
        branch_mispredict = 1'b0; w_retire = 1'b0; w_addr = 8'h00;
        w_wdata = 32'h0; w_zero = 1'b0; en_m = 1'b1;
        cyc_m = 32'h0; inst_m = 32'h0; br_m = 32'h0; mis_m = 32'h0;
        scyc_m = 32'h0; sinst_m = 32'h0; sbr_m = 32'h0; smis_m = 32'h0;
        total_m = 32'h0;

        // Reset state
        tick();
        rst = 1'b0;
        check("rst_cycle", cycle_counter, 32'd0);
        check("rst_instret", instruction_counter, 32'd0);
        check("rst_rdata", mmio_rdata, 32'd0);
        check("rst_wrap_inst", w_inst, 32'hFFFF_FFFF);

        // Idle count and first loads
        repeat (100) tick();
        rd(8'h10, 32'd100, "idle_cycles");
        rd(8'h14, 32'd0, "idle_instret");
        rd(8'h24, 32'd1, "ctrl_reset");

        // Retire pattern: 7 instructions, 3 branches, 1 mispredict
        for (int i = 0; i < 9; i++) begin
            inst_retire       = PAT[i][2];
            branch_retire     = PAT[i][1];
            branch_mispredict = PAT[i][0];
            tick();
        end
        inst_retire = 1'b0; branch_retire = 1'b0; branch_mispredict = 1'b0;
        rd(8'h14, 32'd7, "instret_7");
        rd(8'h1C, 32'd3, "branch_3");
        rd(8'h20, 32'd1, "mispred_1");
        rd(8'h10, model_read(8'h10), "cycles_model");
        repeat (2) tick();
        check("rdata_hold", mmio_rdata, model_read(8'h10) - 32'd3);

        // Clear beats a same-cycle retire
        inst_retire = 1'b1;
        st(8'h18, 32'hDEAD_BEEF);
        inst_retire = 1'b0;
        check("clear_instret", instruction_counter, 32'd0);
        check("clear_cycle0", cycle_counter, 32'd0);
        tick();
        check("clear_cycle1", cycle_counter, 32'd1);
        rd(8'h1C, 32'd0, "clear_branch");

        // Pause, then snapshot and resume
        st(8'h24, 32'h0);
        p = cyc_m;
        check("pause_value", cycle_counter, p);
        repeat (50) tick();
        check("paused_hold", cycle_counter, p);
        st(8'h24, 32'h3);
        rd(8'h30, p, "snap_cycles");
        check("resume_1", cycle_counter, p + 32'd1);
        tick();
        check("resume_2", cycle_counter, p + 32'd2);
        rd(8'h34, 32'd0, "snap_instret");
        rd(8'h24, 32'd1, "ctrl_snap_reads0");

        // Load and store together: load returns the pre-store value
        mmio_addr = 8'h24; mmio_wdata = 32'h0; mmio_re = 1'b1; mmio_we = 1'b1;
        exp_q.push_back(32'd1); tag_q.push_back("re_we_prestore");
        tick();
        mmio_re = 1'b0; mmio_we = 1'b0;
        pop_check();
        rd(8'h24, 32'd0, "re_we_stored");
        st(8'h24, 32'h1);

        // Unmapped, read-only and low-address-bit cases
        rd(8'h40, 32'd0, "unmapped_40");
        rd(8'h28, 32'd0, "unmapped_28");
        st(8'h10, 32'h0000_1234);
        rd(8'h10, model_read(8'h10), "ro_store_ignored");
        rd(8'h17, model_read(8'h14), "addr_low_bits");

        // Wrap from all-ones
        w_retire = 1'b1;
        tick();
        w_retire = 1'b0;
        check("wrap_instret", w_inst, 32'd0);
        check("wrap_cycles", w_cyc, total_m);
        check("wrap_rdata", w_rdata, 32'd0);

        // Reset mid-count with a CTRL store pending
        inst_retire = 1'b1;
        repeat (5) tick();
        inst_retire = 1'b0;
        rd(8'h14, model_read(8'h14), "pre_reset_instret");
        rst = 1'b1; mmio_addr = 8'h24; mmio_wdata = 32'h0; mmio_we = 1'b1;
        tick();
        rst = 1'b0; mmio_we = 1'b0;
        check("mid_rst_cycle", cycle_counter, 32'd0);
        check("mid_rst_instret", instruction_counter, 32'd0);
        check("mid_rst_rdata", mmio_rdata, 32'd0);
        rd(8'h24, 32'd1, "mid_rst_ctrl");
        rd(8'h30, 32'd0, "mid_rst_snap");
        rd(8'h14, 32'd0, "mid_rst_instret_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
